// File: rtl/lane_deserializer_if.sv
// Bundle between the lane deserializer and its surroundings: demux lanes in,
// assembled words out over valid/ready, plus the overflow flag controls.
interface lane_deserializer_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       sel;
    logic             bit_valid;
    logic             in1;
    logic             in2;
    logic             in3;
    logic             in4;
    logic             out_ready;
    logic             ovf_clr;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_lane;
    logic [3:0]       ovf;

    modport master (
        output sel, bit_valid, in1, in2, in3, in4, out_ready, ovf_clr,
        input  out_valid, out_data, out_lane, ovf
    );

    modport slave (
        input  sel, bit_valid, in1, in2, in3, in4, out_ready, ovf_clr,
        output out_valid, out_data, out_lane, ovf
    );
endinterface

// File: rtl/lane_deserializer.sv
// Four-lane bit packer with one holding buffer per lane and a round-robin output stage.
// Define DESER_MSB_FIRST_EN to pack MSB-first; otherwise bits are packed LSB-first.
module lane_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    lane_deserializer_if.slave bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shift_q [4];
    logic [WIDTH-1:0] shift_d [4];
    logic [CNT_W-1:0] cnt_q   [4];
    logic [CNT_W-1:0] cnt_d   [4];
    logic [WIDTH-1:0] buf_q   [4];
    logic [WIDTH-1:0] buf_d   [4];
    logic [3:0]       full_q;
    logic [3:0]       full_d;
    logic [3:0]       ovf_q;
    logic [3:0]       ovf_d;
    logic [1:0]       rr_q;
    logic [1:0]       rr_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic [1:0]       out_lane_q;
    logic [1:0]       out_lane_d;

    logic             cur_bit_s;
    logic [WIDTH-1:0] word_s;
    logic             load_s;
    logic             pick_vld_s;
    logic [1:0]       pick_s;

    // Select the bit of the addressed lane and form that lane's shifted word.
    always_comb begin
        cur_bit_s = 1'b0;
        case (bus.sel)
            2'd0:    cur_bit_s = bus.in1;
            2'd1:    cur_bit_s = bus.in2;
            2'd2:    cur_bit_s = bus.in3;
            2'd3:    cur_bit_s = bus.in4;
            default: cur_bit_s = 1'b0;
        endcase
`ifdef DESER_MSB_FIRST_EN
        word_s = {shift_q[bus.sel][WIDTH-2:0], cur_bit_s};
`else
        word_s = {cur_bit_s, shift_q[bus.sel][WIDTH-1:1]};
`endif
    end

    // Round-robin pick: first full buffer at or after rr_q, lowest offset wins.
    always_comb begin
        logic [1:0] scan;
        scan       = 2'd0;
        pick_vld_s = 1'b0;
        pick_s     = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            scan = rr_q + 2'(k);
            if (full_q[scan]) begin
                pick_vld_s = 1'b1;
                pick_s     = scan;
            end else begin
                pick_vld_s = pick_vld_s;
            end
        end
    end

    assign load_s = !out_valid_q || bus.out_ready;

    // Output register next state: reload when empty or when the consumer takes the word.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_lane_d  = out_lane_q;
        rr_d        = rr_q;
        if (load_s) begin
            if (pick_vld_s) begin
                out_valid_d = 1'b1;
                out_data_d  = buf_q[pick_s];
                out_lane_d  = pick_s;
                rr_d        = pick_s + 2'd1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Lane state: shift/count capture, buffer fill or drop, and overflow flags.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            shift_d[i] = shift_q[i];
            cnt_d[i]   = cnt_q[i];
            buf_d[i]   = buf_q[i];
        end
        full_d = full_q;
        ovf_d  = bus.ovf_clr ? 4'b0000 : ovf_q;

        // Free the drained buffer first so a same-edge completion can refill it.
        if (load_s && pick_vld_s) begin
            full_d[pick_s] = 1'b0;
        end else begin
            full_d = full_d;
        end

        if (bus.bit_valid) begin
            shift_d[bus.sel] = word_s;
            if (cnt_q[bus.sel] == CNT_LAST) begin
                cnt_d[bus.sel] = {CNT_W{1'b0}};
                if (!full_d[bus.sel]) begin
                    buf_d[bus.sel]  = word_s;
                    full_d[bus.sel] = 1'b1;
                end else begin
                    ovf_d[bus.sel] = 1'b1;
                end
            end else begin
                cnt_d[bus.sel] = cnt_q[bus.sel] + CNT_W'(1);
            end
        end else begin
            full_d = full_d;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                shift_q[i] <= {WIDTH{1'b0}};
                cnt_q[i]   <= {CNT_W{1'b0}};
                buf_q[i]   <= {WIDTH{1'b0}};
            end
            full_q      <= 4'b0000;
            ovf_q       <= 4'b0000;
            rr_q        <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
            out_lane_q  <= 2'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                shift_q[i] <= shift_d[i];
                cnt_q[i]   <= cnt_d[i];
                buf_q[i]   <= buf_d[i];
            end
            full_q      <= full_d;
            ovf_q       <= ovf_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_lane_q  <= out_lane_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_lane  = out_lane_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_lane_deserializer.sv
// Directed bench for lane_deserializer (WIDTH=8); expectations follow DESER_MSB_FIRST_EN.
module tb_lane_deserializer;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic hold_chk;
    logic [7:0] hold_data;
    logic [1:0] hold_lane;

    lane_deserializer_if #(.WIDTH(8)) bus ();

    lane_deserializer #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic [1:0] lane, input logic b);
        bus.sel       = lane;
        bus.bit_valid = 1'b1;
        bus.in1       = 1'($urandom);
        bus.in2       = 1'($urandom);
        bus.in3       = 1'($urandom);
        bus.in4       = 1'($urandom);
        case (lane)
            2'd0:    bus.in1 = b;
            2'd1:    bus.in2 = b;
            2'd2:    bus.in3 = b;
            default: bus.in4 = b;
        endcase
        tick();
        bus.bit_valid = 1'b0;
        if (hold_chk) begin
            check_val("hold_data", 32'(bus.out_data), 32'(hold_data));
            check_val("hold_lane", 32'(bus.out_lane), 32'(hold_lane));
        end
    endtask

    task automatic send_word(input logic [1:0] lane, input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
`ifdef DESER_MSB_FIRST_EN
            send_bit(lane, w[7-i]);
`else
            send_bit(lane, w[i]);
`endif
        end
    endtask

    initial begin
        logic [7:0] raw;
        logic [7:0] exp1;
        logic [7:0] rr_data [4];
        n_checks  = 0;
        n_fail    = 0;
        hold_chk  = 1'b0;
        hold_data = 8'h00;
        hold_lane = 2'd0;
        rst_n         = 1'b0;
        bus.sel       = 2'd0;
        bus.bit_valid = 1'b0;
        bus.in1       = 1'b0;
        bus.in2       = 1'b0;
        bus.in3       = 1'b0;
        bus.in4       = 1'b0;
        bus.out_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        tick();
        tick();
        check_val("rst_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_data",  32'(bus.out_data),  32'd0);
        check_val("rst_lane",  32'(bus.out_lane),  32'd0);
        check_val("rst_ovf",   32'(bus.ovf),       32'd0);
        rst_n = 1'b1;
        tick();

        // Single word on lane 0: raw bit sequence 1,0,1,1,0,0,1,0.
        bus.out_ready = 1'b1;
        raw = 8'b0100_1101;
`ifdef DESER_MSB_FIRST_EN
        exp1 = 8'hB2;
`else
        exp1 = 8'h4D;
`endif
        for (int i = 0; i < 8; i++) begin
            send_bit(2'd0, raw[i]);
        end
        check_val("single_early", 32'(bus.out_valid), 32'd0);
        tick();
        check_val("single_valid", 32'(bus.out_valid), 32'd1);
        check_val("single_data",  32'(bus.out_data),  32'(exp1));
        check_val("single_lane",  32'(bus.out_lane),  32'd0);
        tick();
        check_val("single_once",  32'(bus.out_valid), 32'd0);

        // Round-robin drain of four buffered words.
        bus.out_ready = 1'b0;
        rr_data[0] = 8'h11;
        rr_data[1] = 8'h22;
        rr_data[2] = 8'h33;
        rr_data[3] = 8'h44;
        for (int l = 0; l < 4; l++) begin
            send_word(2'(l), rr_data[l]);
        end
        bus.out_ready = 1'b1;
        for (int l = 0; l < 4; l++) begin
            check_val("rr_valid", 32'(bus.out_valid), 32'd1);
            check_val("rr_data",  32'(bus.out_data),  32'(rr_data[l]));
            check_val("rr_lane",  32'(bus.out_lane),  32'(l));
            tick();
        end
        check_val("rr_empty", 32'(bus.out_valid), 32'd0);

        // Overflow on lane 2: third word is dropped.
        bus.out_ready = 1'b0;
        send_word(2'd2, 8'hA1);
        send_word(2'd2, 8'hA2);
        send_word(2'd2, 8'hA3);
        check_val("ovf_flag", 32'(bus.ovf),      32'h4);
        check_val("ovf_data", 32'(bus.out_data), 32'hA1);
        check_val("ovf_lane", 32'(bus.out_lane), 32'd2);
        bus.out_ready = 1'b1;
        tick();
        check_val("ovf_second", 32'(bus.out_data),  32'hA2);
        check_val("ovf_valid2", 32'(bus.out_valid), 32'd1);
        tick();
        check_val("ovf_no_a3",  32'(bus.out_valid), 32'd0);
        check_val("ovf_sticky", 32'(bus.ovf),       32'h4);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check_val("ovf_clr", 32'(bus.ovf), 32'h0);

        // Backpressure: held word stays put while lanes 0 and 3 complete.
        bus.out_ready = 1'b0;
        send_word(2'd1, 8'h5A);
        tick();
        check_val("bp_valid", 32'(bus.out_valid), 32'd1);
        hold_data = 8'h5A;
        hold_lane = 2'd1;
        hold_chk  = 1'b1;
        send_word(2'd0, 8'h77);
        send_word(2'd3, 8'h99);
        hold_chk  = 1'b0;
        check_val("bp_still_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        check_val("bp_next_data", 32'(bus.out_data), 32'h99);
        check_val("bp_next_lane", 32'(bus.out_lane), 32'd3);
        tick();
        check_val("bp_last_data", 32'(bus.out_data), 32'h77);
        check_val("bp_last_lane", 32'(bus.out_lane), 32'd0);
        tick();
        check_val("bp_empty", 32'(bus.out_valid), 32'd0);

        // Reset in the middle of a lane 1 word.
        for (int i = 0; i < 5; i++) begin
            send_bit(2'd1, 1'(i % 2));
        end
        rst_n = 1'b0;
        #1;
        check_val("arst_data",  32'(bus.out_data),  32'd0);
        check_val("arst_valid", 32'(bus.out_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        send_word(2'd1, 8'hFF);
        check_val("mid_no_early", 32'(bus.out_valid), 32'd0);
        tick();
        check_val("mid_valid", 32'(bus.out_valid), 32'd1);
        check_val("mid_data",  32'(bus.out_data),  32'hFF);
        check_val("mid_lane",  32'(bus.out_lane),  32'd1);
        check_val("mid_ovf",   32'(bus.ovf),       32'd0);
        tick();
        check_val("mid_single", 32'(bus.out_valid), 32'd0);

        // Idle lanes: noise with bit_valid low must not disturb anything.
        for (int i = 0; i < 50; i++) begin
            bus.sel = 2'($urandom);
            bus.in1 = 1'($urandom);
            bus.in2 = 1'($urandom);
            bus.in3 = 1'($urandom);
            bus.in4 = 1'($urandom);
            tick();
            check_val("idle_valid", 32'(bus.out_valid), 32'd0);
        end
        send_word(2'd3, 8'hC3);
        tick();
        check_val("idle_word_valid", 32'(bus.out_valid), 32'd1);
        check_val("idle_word_data",  32'(bus.out_data),  32'hC3);
        check_val("idle_word_lane",  32'(bus.out_lane),  32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
